// File: rtl/sr04_meas_scheduler.sv
// sr04_meas_scheduler
//   Sequences the HC-SR04 ranging controller. Issues start pulses on a single-shot
//   request or continuously in auto mode. Each measurement is bounded by an echo
//   timeout, and start pulses are spaced by at least PERIOD_US. The accepted
//   distance is held in a result register.
//
//   Optional build macro: SR04_AVG4_EN
//     defined   : o_dist is the mean of the last 4 accepted readings (2-clk latency)
//     undefined : o_dist is the raw latched reading (1-clk latency)
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   i_auto_en    level, continuous measurements at PERIOD_US
//   i_single     1-cycle pulse, request one measurement
//   i_dist_done  1-cycle pulse from ranging controller, measurement complete
//   i_dist[13:0] distance (cm), valid with i_dist_done
//   o_start      1-cycle start pulse to ranging controller (registered)
//   o_dist[13:0] last accepted distance (cm)
//   o_valid      1-cycle pulse, o_dist updated
//   o_timeout    1-cycle pulse, measurement timed out
//   o_busy       high while a measurement or its hold-off is in progress
//   o_err_cnt    saturating timeout counter
module sr04_meas_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_auto_en,
  input  logic        i_single,
  input  logic        i_dist_done,
  input  logic [13:0] i_dist,
  output logic        o_start,
  output logic [13:0] o_dist,
  output logic        o_valid,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_HOLD} state_t;

  state_t        r_state, w_next;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_us;
  logic          r_pend;
  logic          r_start;
  logic          r_valid;
  logic [13:0]   r_dist;
  logic [7:0]    r_err;

  logic w_tick, w_accept, w_tmo_hit, w_period_hit;

  assign w_tick       = (r_presc == PW'(DIV - 1));
  assign w_accept     = (r_state == S_WAIT) & i_dist_done;
  // dist_done on the timeout cycle takes priority over the timeout
  assign w_tmo_hit    = (r_state == S_WAIT) & ~i_dist_done & (r_us == 16'(TIMEOUT_US));
  assign w_period_hit = (r_us == 16'(PERIOD_US));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_timeout = 1'b0;
    o_busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (i_auto_en | r_pend | i_single) w_next = S_TRIG;
      S_TRIG: w_next = S_WAIT;
      S_WAIT: begin
        if (w_accept) w_next = S_HOLD;
        else if (w_tmo_hit) begin
          w_next    = S_HOLD;
          o_timeout = 1'b1;
        end
      end
      S_HOLD: if (w_period_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Timebase is zeroed on entry to TRIG so the TRIG cycle is count 0; with the
  // HOLD->IDLE->TRIG hop this gives start spacing of PERIOD_US*DIV + 2 clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_us    <= '0;
    end else if (w_next == S_TRIG) begin
      r_presc <= '0;
      r_us    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_us    <= r_us + 16'(w_tick);
    end
  end

  // Requests while busy collapse into one pending bit. The TRIG cycle consumes
  // it, but a request landing exactly on that cycle is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_start <= 1'b0;
      r_err   <= '0;
    end else begin
      r_pend  <= (r_state == S_TRIG) ? i_single : (r_pend | (i_single & (r_state != S_IDLE)));
      r_start <= (w_next == S_TRIG);
      if (w_tmo_hit && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

`ifdef SR04_AVG4_EN
  logic [3:0][13:0] r_hist;
  logic             r_filled;
  logic             r_avg_go;
  logic [15:0]      w_sum;

  assign w_sum = 16'(r_hist[0]) + 16'(r_hist[1]) + 16'(r_hist[2]) + 16'(r_hist[3]);

  // Stage 1 updates the history, stage 2 registers the mean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist   <= '0;
      r_filled <= 1'b0;
      r_avg_go <= 1'b0;
      r_valid  <= 1'b0;
      r_dist   <= '0;
    end else begin
      r_avg_go <= w_accept;
      r_valid  <= r_avg_go;
      if (w_accept) begin
        r_filled <= 1'b1;
        if (!r_filled) r_hist <= {4{i_dist}};
        else           r_hist <= {r_hist[2:0], i_dist};
      end
      if (r_avg_go) r_dist <= w_sum[15:2];
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dist  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) r_dist <= i_dist;
    end
  end
`endif

  assign o_start   = r_start;
  assign o_valid   = r_valid;
  assign o_dist    = r_dist;
  assign o_err_cnt = r_err;

endmodule

// File: tb/tb_sr04_meas_scheduler.sv
// Bench for sr04_meas_scheduler (default build). Timebase scaled: 4 clk/us,
// PERIOD_US=20, TIMEOUT_US=10. Expected event times are derived from the
// scheduling rules: start spacing PERIOD*DIV+2, timeout TIMEOUT*DIV after start,
// o_valid one clock after dist_done, busy drops PERIOD*DIV+1 after start.
module tb_sr04_meas_scheduler;

  localparam int CLK_HZ = 4_000_000;
  localparam int P_US   = 20;
  localparam int T_US   = 10;
  localparam int DIV    = CLK_HZ / 1_000_000;
  localparam int PD     = P_US * DIV;
  localparam int TD     = T_US * DIV;

  logic        clk, rst, i_auto_en, i_single, i_dist_done;
  logic [13:0] i_dist;
  logic        o_start, o_valid, o_timeout, o_busy;
  logic [13:0] o_dist;
  logic [7:0]  o_err_cnt;

  sr04_meas_scheduler #(.CLK_HZ(CLK_HZ), .PERIOD_US(P_US), .TIMEOUT_US(T_US)) dut (
    .clk(clk), .rst(rst), .i_auto_en(i_auto_en), .i_single(i_single),
    .i_dist_done(i_dist_done), .i_dist(i_dist), .o_start(o_start), .o_dist(o_dist),
    .o_valid(o_valid), .o_timeout(o_timeout), .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // event log, sampled mid-cycle
  int   start_q[$], valid_q[$], tmo_q[$], fall_q[$];
  int   vdist_q[$];
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_start)   start_q.push_back(cyc);
      if (o_valid)   begin valid_q.push_back(cyc); vdist_q.push_back(int'(o_dist)); end
      if (o_timeout) tmo_q.push_back(cyc);
      if (prev_busy && !o_busy) fall_q.push_back(cyc);
    end
    prev_busy <= o_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    start_q.delete(); valid_q.delete(); tmo_q.delete(); fall_q.delete(); vdist_q.delete();
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic settle(input int t);
    to_cycle(t);
    @(negedge clk);
  endtask

  task automatic pulse_single(input int t);
    to_cycle(t);
    i_single = 1'b1;
    @(posedge clk); #1;
    i_single = 1'b0;
  endtask

  task automatic pulse_dd(input int t, input logic [13:0] d);
    to_cycle(t);
    i_dist_done = 1'b1;
    i_dist      = d;
    @(posedge clk); #1;
    i_dist_done = 1'b0;
    i_dist      = 14'($urandom);
  endtask

  task automatic wait_start(input int n, input int budget, output int ts);
    for (int k = 0; k < budget && start_q.size() < n; k++) @(negedge clk);
    chk("start_seen", 32'(start_q.size() >= n), 1);
    ts = (start_q.size() >= n) ? start_q[n-1] : cyc;
  endtask

  task automatic wait_tmo(input int n, input int budget);
    for (int k = 0; k < budget && tmo_q.size() < n; k++) @(negedge clk);
    chk("tmo_seen", 32'(tmo_q.size() >= n), 1);
  endtask

  initial begin
    int ts, c, d, err_exp, bad, n1;
    logic [13:0] v, last_dist;
    int exp_vc[$];
    int exp_vd[$];

    rst = 1'b1; i_auto_en = 1'b0; i_single = 1'b0; i_dist_done = 1'b0; i_dist = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", o_start, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_tmo",   o_timeout, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_dist",  o_dist, 0);
    chk("rst_err",   o_err_cnt, 0);
    @(posedge clk); #1; rst = 1'b0;
    err_exp = 0;

    // 1: single measurement with dist_done inside the window
    clr_logs();
    c = cyc + 2;
    pulse_single(c);
    wait_start(1, 10, ts);
    chk("t1_start_lat", ts, c + 1);
    d = $urandom_range(TD - 1, 1);
    v = 14'($urandom);
    pulse_dd(ts + d, v);
    settle(ts + PD + 3);
    chk("t1_nvalid", valid_q.size(), 1);
    chk("t1_valid_cyc", (valid_q.size() > 0) ? valid_q[0] : -1, ts + d + 1);
    chk("t1_dist", o_dist, v);
    chk("t1_ntmo", tmo_q.size(), 0);
    chk("t1_nstart", start_q.size(), 1);
    chk("t1_busy_fall", (fall_q.size() > 0) ? fall_q[0] : -1, ts + PD + 1);
    last_dist = v;

    // 2: no dist_done -> timeout
    clr_logs();
    pulse_single(cyc + 2);
    wait_start(1, 10, ts);
    settle(ts + PD + 3);
    err_exp++;
    chk("t2_ntmo", tmo_q.size(), 1);
    chk("t2_tmo_cyc", (tmo_q.size() > 0) ? tmo_q[0] : -1, ts + TD);
    chk("t2_err", o_err_cnt, err_exp);
    chk("t2_dist_kept", o_dist, last_dist);
    chk("t2_nvalid", valid_q.size(), 0);
    chk("t2_busy_fall", (fall_q.size() > 0) ? fall_q[0] : -1, ts + PD + 1);

    // 3: auto mode, 5 periods, random echo per period
    clr_logs();
    to_cycle(cyc + 2);
    i_auto_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start(k + 1, PD + 20, ts);
      if (k > 0) chk("t3_spacing", ts - start_q[k-1], PD + 2);
      d = $urandom_range(TD - 1, 1);
      v = 14'($urandom);
      exp_vc.push_back(ts + d + 1);
      exp_vd.push_back(int'(v));
      pulse_dd(ts + d, v);
      last_dist = v;
    end
    i_auto_en = 1'b0;
    settle(ts + PD + 40);
    chk("t3_nstart", start_q.size(), 5);
    chk("t3_nvalid", valid_q.size(), 5);
    bad = 0;
    for (int k = 0; k < 5; k++)
      if (k >= valid_q.size() || valid_q[k] != exp_vc[k] || vdist_q[k] != exp_vd[k]) bad++;
    chk("t3_valid_seq", bad, 0);
    chk("t3_err", o_err_cnt, err_exp);

    // 4: three requests during WAIT collapse into one follow-up start
    clr_logs();
    pulse_single(cyc + 2);
    wait_start(1, 10, ts);
    pulse_single(ts + 3);
    pulse_single(ts + 8 + $urandom_range(5, 0));
    pulse_single(ts + 20);
    pulse_dd(ts + 30, 14'd77);
    settle(ts + 2 * PD + 10);
    err_exp++;
    chk("t4_nstart", start_q.size(), 2);
    chk("t4_start2", (start_q.size() > 1) ? start_q[1] - ts : -1, PD + 2);
    chk("t4_nvalid", valid_q.size(), 1);
    chk("t4_err", o_err_cnt, err_exp);
    last_dist = 14'd77;

    // 5a: dist_done exactly on the timeout cycle wins
    clr_logs();
    pulse_single(cyc + 2);
    wait_start(1, 10, ts);
    v = 14'($urandom);
    pulse_dd(ts + TD, v);
    settle(ts + PD + 3);
    chk("t5a_valid_cyc", (valid_q.size() > 0) ? valid_q[0] : -1, ts + TD + 1);
    chk("t5a_dist", o_dist, v);
    chk("t5a_ntmo", tmo_q.size(), 0);
    chk("t5a_err", o_err_cnt, err_exp);

    // 5b: 260 back-to-back timeouts saturate the error counter
    clr_logs();
    to_cycle(cyc + 2);
    i_auto_en = 1'b1;
    n1 = 254 - err_exp;
    wait_tmo(n1, n1 * (PD + 2) + 200);
    @(negedge clk);
    chk("t5b_err_254", o_err_cnt, 254);
    wait_tmo(260, (260 - n1) * (PD + 2) + 200);
    @(negedge clk);
    chk("t5b_err_sat", o_err_cnt, 255);
    i_auto_en = 1'b0;
    bad = 0;
    for (int k = 1; k < tmo_q.size(); k++) if (tmo_q[k] - tmo_q[k-1] != PD + 2) bad++;
    chk("t5b_tmo_spacing", bad, 0);
    settle(cyc + 2 * PD + 10);
    chk("t5b_err_hold", o_err_cnt, 255);
    chk("t5b_idle", o_busy, 0);

    // 6: reset mid-WAIT, then a stray dist_done
    clr_logs();
    pulse_single(cyc + 2);
    wait_start(1, 10, ts);
    to_cycle(ts + 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", o_busy, 0);
    chk("t6_err",  o_err_cnt, 0);
    chk("t6_dist", o_dist, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_logs();
    pulse_dd(cyc + 2, 14'($urandom));
    settle(cyc + PD);
    chk("t6_nvalid", valid_q.size(), 0);
    chk("t6_nstart", start_q.size(), 0);
    chk("t6_dist_after", o_dist, 0);
    chk("t6_busy_after", o_busy, 0);
    chk("t6_err_after", o_err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
